ffd_write_arbiter: RTL and testbench
====================================

# ffd_write_arbiter

Round-robin write controller that shares one WIDTH-bit flip-flop register among NREQ requesters. Each requester presents a request and a data word; the block grants one requester at a time, loads that word into the register, and returns a one-cycle acknowledge. Synchronous set and clear commands override arbitration. It sits between the lab's requester logic and the shared register, and its Q output drives downstream displays and logic.

## Interface
- WIDTH, 4, register and data width
- NREQ, 3, number of requesters (2..8)
- clock  in  1  rising-edge clock
- RST  in  1  reset, asynchronous, active-low
- req  in  NREQ  per-requester write request, level
- wdata  in  NREQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
- st  in  1  synchronous set: Q <= all ones
- clr  in  1  synchronous clear: Q <= 0
- Q  out  WIDTH  shared register contents
- gnt  out  NREQ  one-hot grant, registered
- ack  out  NREQ  one-hot write-done pulse, registered, one cycle
- busy  out  1  high while state is GRANT

## Operation
- Reset (RST=0, asynchronous): Q=0, gnt=0, ack=0, busy=0, state IDLE, ptr=NREQ-1, so requester 0 has first priority.
- States: IDLE and GRANT.
- ack defaults to 0 on every edge unless a write completes on that edge.
- Priority on every edge: clr, then st, then the FSM.
  - clr=1: Q <= 0.
  - clr=0, st=1: Q <= {WIDTH{1'b1}}.
  - If either command hits while in GRANT, the pending write aborts: no load, no ack, gnt <= 0, ptr unchanged, next state IDLE.
  - If either command hits in IDLE, no grant is issued on that edge.
- IDLE, with req nonzero and no command:
  - Winner = first set req bit searching ptr+1, ptr+2, … modulo NREQ.
  - gnt <= onehot(winner), next state GRANT.
- GRANT, req[winner]=1, no command:
  - Q <= wdata[winner] and ack <= onehot(winner).
  - gnt <= 0, ptr <= winner, next state IDLE.
- GRANT, req[winner]=0 (requester withdrew): abort as for commands. Q is unchanged.
- Requester contract:
  - Hold req and wdata stable from assertion until ack is seen.
  - Drop req in the ack cycle, or it counts as a new request.
- ptr changes only on a completed write.
- A requester that has just been served is last in priority on the next arbitration.

## Timing
- A request sampled at edge E0 in IDLE: gnt high after E0.
- At edge E1: Q updated and ack high for exactly one cycle after E1. Request-to-Q latency is 2 edges.
- Back-to-back arbitration: the next grant can issue at E2. Maximum throughput is one write per 2 cycles.
- With all requesters continuously requesting, they are served in order 0,1,2,0,…
- clr and st take effect at the next edge with 1-cycle latency, in any state.
- gnt, ack and busy are flop outputs with no combinational path from the inputs.
- RST asserted mid-GRANT clears everything immediately. No ack is produced.

## Structure
- Package ffd_arb_pkg:
  - state enum {IDLE, GRANT}
  - default WIDTH and NREQ constants
- Sub-module rr_pick: a combinational round-robin picker with inputs req[NREQ] and ptr, and outputs a one-hot winner and its index. The FSM, ptr register and Q register live in ffd_write_arbiter.

## Test plan
- Reset: drive RST=0 mid-run → Q=0000, gnt=000, ack=000, busy=0 immediately. After release, req=111 → requester 0 is granted first.
- Single write: req=010, wdata[1]=0110 → gnt=010 after edge 1; Q=0110 and ack=010 after edge 2; ack low after edge 3.
- Fairness: req=111 held continuously (each requester re-asserts after its ack), data 1100/0011/1010 → Q sequence 1100, 0011, 1010, 1100; grants 001, 010, 100, 001.
- Commands: Q=0101, then st=1 → Q=1111. Then clr=1 and st=1 on the same edge → Q=0000.
- Abort: in GRANT for requester 2, drop req[2] → no ack, Q unchanged, ptr unchanged. Then req=101 → requester 0 granted.
- Command vs write: st=1 on the GRANT edge of requester 0 with data 0011 → Q=1111, ack=000, and requester 0 is re-granted on its next request.

Source files
------------

// File: rtl/ffd_arb_pkg.sv
// Shared types and default sizing for the round-robin write arbiter
// that owns the lab's shared flip-flop register.
package ffd_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_NREQ  = 3;

endpackage

// File: rtl/ffd_write_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first set request after the
// pointer, wrapping modulo NREQ, and reports it one-hot and as an index.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int PTRW = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PTRW-1:0] i_ptr,
  output logic [NREQ-1:0] o_onehot,
  output logic [PTRW-1:0] o_idx
);

  logic            w_found;
  logic [PTRW-1:0] w_cand;

  // Search ptr+1, ptr+2, ... so the last-served requester is checked last.
  always_comb begin
    w_found  = 1'b0;
    w_cand   = '0;
    o_onehot = '0;
    o_idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = PTRW'((int'(i_ptr) + k) % NREQ);
      if (!w_found && i_req[w_cand]) begin
        w_found  = 1'b1;
        o_idx    = w_cand;
        o_onehot = NREQ'(1) << w_cand;
      end
    end
  end

endmodule

// File: rtl/ffd_write_arbiter.sv
// Round-robin write controller sharing one WIDTH-bit register among NREQ
// requesters; synchronous clear/set commands override arbitration.
module ffd_write_arbiter
  import ffd_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int NREQ  = DEFAULT_NREQ
) (
  input  logic                  clock,
  input  logic                  RST,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  input  logic                  st,
  input  logic                  clr,
  output logic [WIDTH-1:0]      Q,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic                  busy
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          r_state;
  logic [WIDTH-1:0] r_q;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_ack;
  logic [PTRW-1:0]  r_ptr;
  logic [PTRW-1:0]  r_winIdx;

  logic [NREQ-1:0]  w_pickOnehot;
  logic [PTRW-1:0]  w_pickIdx;
  logic [WIDTH-1:0] w_selData;
  logic             w_cmd;
  logic             w_stillReq;

  rr_pick #(
    .NREQ (NREQ),
    .PTRW (PTRW)
  ) u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_pickOnehot),
    .o_idx    (w_pickIdx)
  );

  assign w_selData  = wdata[int'(r_winIdx)*WIDTH +: WIDTH];
  assign w_cmd      = clr | st;
  assign w_stillReq = |(req & r_gnt);

  // Commands win over any pending write; a withdrawn request aborts the same
  // way. The pointer only moves when a write actually lands.
  always_ff @(posedge clock or negedge RST) begin
    if (!RST) begin
      r_state  <= IDLE;
      r_q      <= '0;
      r_gnt    <= '0;
      r_ack    <= '0;
      r_ptr    <= PTRW'(NREQ - 1);
      r_winIdx <= '0;
    end else begin
      r_ack <= '0;
      if (clr) begin
        r_q <= '0;
      end else if (st) begin
        r_q <= '1;
      end
      if (w_cmd) begin
        r_gnt   <= '0;
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (|req) begin
              r_gnt    <= w_pickOnehot;
              r_winIdx <= w_pickIdx;
              r_state  <= GRANT;
            end
          end
          GRANT: begin
            r_gnt   <= '0;
            r_state <= IDLE;
            if (w_stillReq) begin
              r_q   <= w_selData;
              r_ack <= r_gnt;
              r_ptr <= r_winIdx;
            end
          end
          default: begin
            r_gnt   <= '0;
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign Q    = r_q;
  assign gnt  = r_gnt;
  assign ack  = r_ack;
  assign busy = (r_state == GRANT);

endmodule

// File: tb/tb_ffd_write_arbiter.sv
// Directed bench for ffd_write_arbiter: reset, single write, fairness,
// commands, abort and command-versus-write, with hand-computed expectations.
module tb_ffd_write_arbiter;

  logic        clock;
  logic        RST;
  logic [2:0]  req;
  logic [11:0] wdata;
  logic        st;
  logic        clr;
  logic [3:0]  Q;
  logic [2:0]  gnt;
  logic [2:0]  ack;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;

  ffd_write_arbiter #(
    .WIDTH (4),
    .NREQ  (3)
  ) dut (
    .clock (clock),
    .RST   (RST),
    .req   (req),
    .wdata (wdata),
    .st    (st),
    .clr   (clr),
    .Q     (Q),
    .gnt   (gnt),
    .ack   (ack),
    .busy  (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Inputs change and outputs are sampled 2 time units after each rising edge.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic applyStimulus(input logic [2:0] r, input logic [11:0] d,
                               input logic s, input logic c);
    req   = r;
    wdata = d;
    st    = s;
    clr   = c;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs,
                             input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [3:0] eq,
                          input logic [2:0] eg, input logic [2:0] ea,
                          input logic eb);
    checkOutput({tag, ".Q"},    8'(Q),    8'(eq));
    checkOutput({tag, ".gnt"},  8'(gnt),  8'(eg));
    checkOutput({tag, ".ack"},  8'(ack),  8'(ea));
    checkOutput({tag, ".busy"}, 8'(busy), 8'(eb));
  endtask

  initial begin
    RST = 1'b0;
    applyStimulus(3'b000, 12'h000, 1'b0, 1'b0);
    #1;
    checkAll("reset0", 4'b0000, 3'b000, 3'b000, 1'b0);
    tick();
    tick();
    RST = 1'b1;
    tick();
    checkAll("idle", 4'b0000, 3'b000, 3'b000, 1'b0);

    // Single write from requester 1
    applyStimulus(3'b010, {4'b0000, 4'b0110, 4'b0000}, 1'b0, 1'b0);
    tick();
    checkAll("sw.e1", 4'b0000, 3'b010, 3'b000, 1'b1);
    tick();
    checkAll("sw.e2", 4'b0110, 3'b000, 3'b010, 1'b0);
    req = 3'b000;
    tick();
    checkAll("sw.e3", 4'b0110, 3'b000, 3'b000, 1'b0);

    // Reset asserted mid-GRANT clears everything immediately
    applyStimulus(3'b001, {4'b0000, 4'b0000, 4'b1001}, 1'b0, 1'b0);
    tick();
    checkAll("rst.grant", 4'b0110, 3'b001, 3'b000, 1'b1);
    RST = 1'b0;
    #1;
    checkAll("rst.mid", 4'b0000, 3'b000, 3'b000, 1'b0);
    #1;
    applyStimulus(3'b111, {4'b1010, 4'b0011, 4'b1100}, 1'b0, 1'b0);
    RST = 1'b1;

    // Fairness: all requesting, re-asserting after each ack
    tick();
    checkAll("fair.g0", 4'b0000, 3'b001, 3'b000, 1'b1);
    tick();
    checkAll("fair.w0", 4'b1100, 3'b000, 3'b001, 1'b0);
    req = 3'b110;
    tick();
    checkAll("fair.g1", 4'b1100, 3'b010, 3'b000, 1'b1);
    req = 3'b111;
    tick();
    checkAll("fair.w1", 4'b0011, 3'b000, 3'b010, 1'b0);
    req = 3'b101;
    tick();
    checkAll("fair.g2", 4'b0011, 3'b100, 3'b000, 1'b1);
    req = 3'b111;
    tick();
    checkAll("fair.w2", 4'b1010, 3'b000, 3'b100, 1'b0);
    req = 3'b011;
    tick();
    checkAll("fair.g0b", 4'b1010, 3'b001, 3'b000, 1'b1);
    req = 3'b111;
    tick();
    checkAll("fair.w0b", 4'b1100, 3'b000, 3'b001, 1'b0);
    req = 3'b000;

    // Load 0101 through requester 2, then set, then clear beats set
    applyStimulus(3'b100, {4'b0101, 4'b0000, 4'b0000}, 1'b0, 1'b0);
    tick();
    checkAll("cmd.g2", 4'b1100, 3'b100, 3'b000, 1'b1);
    tick();
    checkAll("cmd.w2", 4'b0101, 3'b000, 3'b100, 1'b0);
    applyStimulus(3'b000, 12'h000, 1'b1, 1'b0);
    tick();
    checkAll("cmd.st", 4'b1111, 3'b000, 3'b000, 1'b0);
    applyStimulus(3'b000, 12'h000, 1'b1, 1'b1);
    tick();
    checkAll("cmd.clrst", 4'b0000, 3'b000, 3'b000, 1'b0);

    // Abort: requester 2 withdraws while granted
    applyStimulus(3'b100, {4'b0111, 4'b0000, 4'b0011}, 1'b0, 1'b0);
    tick();
    checkAll("ab.g2", 4'b0000, 3'b100, 3'b000, 1'b1);
    req = 3'b000;
    tick();
    checkAll("ab.drop", 4'b0000, 3'b000, 3'b000, 1'b0);
    req = 3'b101;
    tick();
    checkAll("ab.g0", 4'b0000, 3'b001, 3'b000, 1'b1);

    // Set lands on requester 0's GRANT edge: write aborted, then re-granted
    st = 1'b1;
    tick();
    checkAll("cw.st", 4'b1111, 3'b000, 3'b000, 1'b0);
    st = 1'b0;
    tick();
    checkAll("cw.regnt", 4'b1111, 3'b001, 3'b000, 1'b1);
    tick();
    checkAll("cw.w0", 4'b0011, 3'b000, 3'b001, 1'b0);
    req = 3'b100;
    tick();
    checkAll("cw.g2", 4'b0011, 3'b100, 3'b000, 1'b1);
    tick();
    checkAll("cw.w2", 4'b0111, 3'b000, 3'b100, 1'b0);
    req = 3'b000;
    tick();
    checkAll("cw.end", 4'b0111, 3'b000, 3'b000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
